// File: rtl/smart_home_pkg.sv
// smart_home_pkg
//   Shared definitions for the smart-home supervisory controller:
//   FSM state encoding (identical to the display code), display code
//   constants and a helper that sizes the door hold timer.
package smart_home_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FDOOR = 3'd1,
    ST_RDOOR = 3'd2,
    ST_WIN   = 3'd3,
    ST_ALARM = 3'd4,
    ST_HEAT  = 3'd5,
    ST_COOL  = 3'd6
  } state_e;

  localparam logic [2:0] DISP_IDLE  = 3'd0;
  localparam logic [2:0] DISP_FDOOR = 3'd1;
  localparam logic [2:0] DISP_RDOOR = 3'd2;
  localparam logic [2:0] DISP_WIN   = 3'd3;
  localparam logic [2:0] DISP_ALARM = 3'd4;
  localparam logic [2:0] DISP_HEAT  = 3'd5;
  localparam logic [2:0] DISP_COOL  = 3'd6;

  // Bits needed to hold the value DOOR_HOLD.
  function automatic int timer_w(input int hold);
    return (hold < 1) ? 1 : $clog2(hold + 1);
  endfunction

  function automatic logic [2:0] disp_code(input state_e s);
    logic [2:0] code;
    case (s)
      ST_FDOOR: code = DISP_FDOOR;
      ST_RDOOR: code = DISP_RDOOR;
      ST_WIN:   code = DISP_WIN;
      ST_ALARM: code = DISP_ALARM;
      ST_HEAT:  code = DISP_HEAT;
      ST_COOL:  code = DISP_COOL;
      default:  code = DISP_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sh_debounce.sv
// sh_debounce
//   Debounce filter for one already-synchronised binary input. q takes
//   the value of d once d has differed from q for DEBOUNCE consecutive
//   samples; any sample equal to q restarts the count.
// Ports:
//   Clk  in  clock, rising edge
//   Rst  in  synchronous active-high reset
//   d    in  synchronised input
//   q    out filtered value
module sh_debounce
  import smart_home_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic Clk,
  input  logic Rst,
  input  logic d,
  output logic q
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

  logic [CW-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      q   <= 1'b0;
      cnt <= '0;
    end else if (d == q) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      q   <= d;
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/smart_home_ctrl_p.sv
// smart_home_ctrl_p
//   Smart-home supervisory controller. Door, window and fire sensors are
//   synchronised by one flop and (optionally) debounced; the temperature
//   sample is registered once. A Moore FSM with priority
//   ALARM > FDOOR > RDOOR > WIN > HEAT/COOL > IDLE drives registered
//   one-hot actuator outputs and a 3-bit display code.
//   Build option: define SMART_HOME_DEBOUNCE_EN to instantiate the
//   debounce filter per input; otherwise the filtered value is the
//   synchronised value.
// Ports:
//   Clk, Rst          clock (rising) and synchronous active-high reset
//   SFD, SRD          front/rear door presence sensors
//   SW[N_WIN]         window-open sensors
//   SFA               fire sensor
//   ST[TEMP_W]        temperature sample (unsigned)
//   alarm_ack         operator acknowledge (level)
//   fdoor, rdoor      door actuators
//   winbuzz, win_open window buzzer and filtered window mask
//   alarmbuzz         fire buzzer
//   heater, cooler    climate actuators
//   display           state code
module smart_home_ctrl_p
  import smart_home_pkg::*;
#(
  parameter int TEMP_W    = 7,
  parameter int N_WIN     = 2,
  parameter int DEBOUNCE  = 4,
  parameter int DOOR_HOLD = 8,
  parameter int HEAT_LO   = 50,
  parameter int COOL_HI   = 60,
  parameter int HYST      = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              SFD,
  input  logic              SRD,
  input  logic [N_WIN-1:0]  SW,
  input  logic              SFA,
  input  logic [TEMP_W-1:0] ST,
  input  logic              alarm_ack,
  output logic              fdoor,
  output logic              rdoor,
  output logic              winbuzz,
  output logic [N_WIN-1:0]  win_open,
  output logic              alarmbuzz,
  output logic              heater,
  output logic              cooler,
  output logic [2:0]        display
);

  if ((HEAT_LO + HYST > COOL_HI - HYST) || (N_WIN < 1) || (DEBOUNCE < 1) || (DOOR_HOLD < 1)) begin : g_bad_params
    $error("smart_home_ctrl_p: invalid parameter set");
  end

  localparam int NI  = N_WIN + 3;
  localparam int TW  = timer_w(DOOR_HOLD);
  localparam int TW1 = TEMP_W + 1;

  // Thresholds widened by one bit so HEAT_LO+HYST cannot wrap.
  localparam logic [TEMP_W:0] HEAT_ON  = TW1'(HEAT_LO);
  localparam logic [TEMP_W:0] HEAT_OFF = TW1'(HEAT_LO + HYST);
  localparam logic [TEMP_W:0] COOL_ON  = TW1'(COOL_HI);
  localparam logic [TEMP_W:0] COOL_OFF = TW1'(COOL_HI - HYST);
  localparam logic [TW-1:0]   HOLD_LOAD = TW'(DOOR_HOLD);

  // Bit order: {SW, SFA, SRD, SFD}
  logic [NI-1:0]     sync;
  logic [NI-1:0]     filt;
  logic [TEMP_W-1:0] st_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync <= '0;
      st_q <= '0;
    end else begin
      sync <= {SW, SFA, SRD, SFD};
      st_q <= ST;
    end
  end

`ifdef SMART_HOME_DEBOUNCE_EN
  for (genvar i = 0; i < NI; i++) begin : g_db
    sh_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
      .Clk (Clk),
      .Rst (Rst),
      .d   (sync[i]),
      .q   (filt[i])
    );
  end
`else
  assign filt = sync;
`endif

  logic             f_sfd, f_srd, f_sfa;
  logic [N_WIN-1:0] f_sw;
  logic [TEMP_W:0]  st_ext;
  logic             heat_req, cool_req;

  assign f_sfd  = filt[0];
  assign f_srd  = filt[1];
  assign f_sfa  = filt[2];
  assign f_sw   = filt[NI-1:3];
  assign st_ext = {1'b0, st_q};

  state_e         state, nxt;
  logic [TW-1:0]  hold_cnt, hold_nxt;

  // Hysteresis: the leaving threshold applies only while already in the band.
  assign heat_req = (state == ST_HEAT) ? (st_ext < HEAT_OFF) : (st_ext < HEAT_ON);
  assign cool_req = (state == ST_COOL) ? (st_ext > COOL_OFF) : (st_ext > COOL_ON);

  // NOTE: defaults at the top of the block keep every path assigned, so
  // no latch is inferred.
  always_comb begin
    nxt      = ST_IDLE;
    hold_nxt = '0;
    if (f_sfa) begin
      nxt = ST_ALARM;
    end else if (state == ST_ALARM) begin
      // Latched: only an ack with the fire sensor low releases it.
      nxt = alarm_ack ? ST_IDLE : ST_ALARM;
    end else if (f_sfd) begin
      nxt      = ST_FDOOR;
      hold_nxt = HOLD_LOAD;
    end else if ((state == ST_FDOOR) && (hold_cnt > TW'(1))) begin
      nxt      = ST_FDOOR;
      hold_nxt = hold_cnt - TW'(1);
    end else if (f_srd) begin
      nxt      = ST_RDOOR;
      hold_nxt = HOLD_LOAD;
    end else if ((state == ST_RDOOR) && (hold_cnt > TW'(1))) begin
      nxt      = ST_RDOOR;
      hold_nxt = hold_cnt - TW'(1);
    end else if (|f_sw) begin
      nxt = ST_WIN;
    end else if (heat_req) begin
      nxt = ST_HEAT;
    end else if (cool_req) begin
      nxt = ST_COOL;
    end
  end

  // Outputs are decoded from the next state and registered with it, so
  // they always agree with the state register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      fdoor     <= 1'b0;
      rdoor     <= 1'b0;
      winbuzz   <= 1'b0;
      win_open  <= '0;
      alarmbuzz <= 1'b0;
      heater    <= 1'b0;
      cooler    <= 1'b0;
      display   <= DISP_IDLE;
    end else begin
      state     <= nxt;
      hold_cnt  <= hold_nxt;
      fdoor     <= (nxt == ST_FDOOR);
      rdoor     <= (nxt == ST_RDOOR);
      winbuzz   <= (nxt == ST_WIN);
      win_open  <= (nxt == ST_WIN) ? f_sw : '0;
      alarmbuzz <= (nxt == ST_ALARM);
      heater    <= (nxt == ST_HEAT);
      cooler    <= (nxt == ST_COOL);
      display   <= disp_code(nxt);
    end
  end

endmodule

// File: tb/tb_smart_home_ctrl_p.sv
// tb_smart_home_ctrl_p
//   Directed scenarios plus randomized stimulus for smart_home_ctrl_p,
//   checked every cycle against a behavioural model. The model filters
//   with a sliding window of recent samples and times door holds with
//   absolute release deadlines. Works with or without
//   SMART_HOME_DEBOUNCE_EN defined.
module tb_smart_home_ctrl_p;

  localparam int TEMP_W    = 7;
  localparam int N_WIN     = 2;
  localparam int DEBOUNCE  = 4;
  localparam int DOOR_HOLD = 8;
  localparam int HEAT_LO   = 50;
  localparam int COOL_HI   = 60;
  localparam int HYST      = 2;
`ifdef SMART_HOME_DEBOUNCE_EN
  localparam bit DBN = 1'b1;
`else
  localparam bit DBN = 1'b0;
`endif
  localparam int LAT = DBN ? DEBOUNCE + 2 : 2;
  localparam int NI  = N_WIN + 3;
  localparam logic [N_WIN-1:0] W_HI = N_WIN'(1) << (N_WIN - 1);

  logic              Clk, Rst, SFD, SRD, SFA, alarm_ack;
  logic [N_WIN-1:0]  SW;
  logic [TEMP_W-1:0] ST;
  logic              fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler;
  logic [N_WIN-1:0]  win_open;
  logic [2:0]        display;

  int total = 0;
  int bad   = 0;
  bit sb_on = 1'b0;

  smart_home_ctrl_p #(
    .TEMP_W(TEMP_W), .N_WIN(N_WIN), .DEBOUNCE(DEBOUNCE), .DOOR_HOLD(DOOR_HOLD),
    .HEAT_LO(HEAT_LO), .COOL_HI(COOL_HI), .HYST(HYST)
  ) dut (
    .Clk(Clk), .Rst(Rst), .SFD(SFD), .SRD(SRD), .SW(SW), .SFA(SFA), .ST(ST),
    .alarm_ack(alarm_ack), .fdoor(fdoor), .rdoor(rdoor), .winbuzz(winbuzz),
    .win_open(win_open), .alarmbuzz(alarmbuzz), .heater(heater), .cooler(cooler),
    .display(display)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // State codes: 0 idle, 1 front door, 2 rear door, 3 window, 4 alarm,
  // 5 heat, 6 cool.
  logic [NI-1:0]    m_sync, m_filt;
  logic [NI-1:0]    m_hist [DEBOUNCE];
  logic [N_WIN-1:0] m_win;
  int m_state, m_release_at, m_cyc, m_st;

  task automatic model_reset();
    m_sync = '0;
    m_filt = '0;
    for (int k = 0; k < DEBOUNCE; k++) m_hist[k] = '0;
    m_win = '0;
    m_state = 0;
    m_release_at = 0;
    m_st = 0;
  endtask

  task automatic model_step();
    logic [NI-1:0]    view;
    logic [N_WIN-1:0] w;
    logic             fd, rd, fa, same;
    int               nxt, heat_limit, cool_limit;
    view = DBN ? m_filt : m_sync;
    fd = view[0];
    rd = view[1];
    fa = view[2];
    w  = view[NI-1:3];
    m_cyc++;
    if (fa) nxt = 4;
    else if (m_state == 4) nxt = alarm_ack ? 0 : 4;
    else if (fd) begin
      nxt = 1;
      m_release_at = m_cyc + DOOR_HOLD;
    end else if (m_state == 1 && m_cyc < m_release_at) nxt = 1;
    else if (rd) begin
      nxt = 2;
      m_release_at = m_cyc + DOOR_HOLD;
    end else if (m_state == 2 && m_cyc < m_release_at) nxt = 2;
    else if (w != 0) nxt = 3;
    else begin
      heat_limit = (m_state == 5) ? HEAT_LO + HYST : HEAT_LO;
      cool_limit = (m_state == 6) ? COOL_HI - HYST : COOL_HI;
      if (m_st < heat_limit) nxt = 5;
      else if (m_st > cool_limit) nxt = 6;
      else nxt = 0;
    end
    m_win   = (nxt == 3) ? w : '0;
    m_state = nxt;
    // Filter: a bit follows its recent samples once the last DEBOUNCE agree.
    for (int k = DEBOUNCE - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = m_sync;
    for (int b = 0; b < NI; b++) begin
      same = 1'b1;
      for (int k = 1; k < DEBOUNCE; k++) if (m_hist[k][b] != m_hist[0][b]) same = 1'b0;
      if (same) m_filt[b] = m_hist[0][b];
    end
    m_sync = {SW, SFA, SRD, SFD};
    m_st   = int'(ST);
  endtask

  initial m_cyc = 0;

  always @(posedge Clk) begin
    if (Rst) model_reset();
    else model_step();
  end

  function automatic logic [31:0] dut_bundle();
    return 32'({display, win_open, fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler});
  endfunction

  function automatic logic [31:0] model_bundle();
    return 32'({m_state[2:0], m_win, (m_state == 1), (m_state == 2), (m_state == 3),
                (m_state == 4), (m_state == 5), (m_state == 6)});
  endfunction

  always @(negedge Clk) if (sb_on) check("model", dut_bundle(), model_bundle());

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      @(negedge Clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int first, highs;
    Rst = 1'b1; SFD = 1'b1; SRD = 1'b1; SW = '1; SFA = 1'b1; ST = 7'd55; alarm_ack = 1'b0;

    // Reset with every sensor active.
    @(posedge Clk);
    sb_on = 1'b1;
    @(negedge Clk);
    check("rst_outputs", dut_bundle(), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_outputs_hold", dut_bundle(), 32'd0);
    end
    Rst = 1'b0;
    first = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (alarmbuzz === 1'b1 && first < 0) first = k;
    end
    check("rst_to_alarm_cycles", first, LAT);
    SFD = 1'b0; SRD = 1'b0; SW = '0; SFA = 1'b0;
    tick(DEBOUNCE + 3);
    alarm_ack = 1'b1;
    tick();
    alarm_ack = 1'b0;
    tick(3);
    check("post_rst_idle", display, 3'd0);

    // Short glitch on SFD.
    SFD = 1'b1;
    highs = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 2) SFD = 1'b0;
      if (fdoor === 1'b1) highs++;
    end
    check("glitch_fdoor_cycles", highs, DBN ? 0 : 2 + DOOR_HOLD - 1);

    // SFD held 10 cycles: latency and hold.
    SFD = 1'b1;
    first = -1;
    highs = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 10) SFD = 1'b0;
      if (fdoor === 1'b1) begin
        if (first < 0) first = k;
        highs++;
      end
    end
    check("fdoor_rise_latency", first, LAT);
    check("fdoor_high_cycles", highs, 10 + DOOR_HOLD - 1);

    // Alarm latch during FDOOR; ack while fire is high is ignored.
    SFD = 1'b1;
    tick(LAT + 1);
    check("latch_fdoor_on", fdoor, 1'b1);
    SFA = 1'b1;
    alarm_ack = 1'b1;
    tick(LAT);
    check("latch_alarmbuzz", alarmbuzz, 1'b1);
    check("latch_display", display, 3'd4);
    check("latch_fdoor_off", fdoor, 1'b0);
    SFA = 1'b0; SFD = 1'b0; alarm_ack = 1'b0;
    tick(20);
    check("latch_held", display, 3'd4);
    alarm_ack = 1'b1;
    tick();
    check("latch_cleared", display, 3'd0);
    alarm_ack = 1'b0;
    tick(20);

    // Temperature hysteresis.
    ST = 7'd49; tick(3); check("heat_49", heater, 1'b1);
    ST = 7'd51; tick(3); check("heat_51", heater, 1'b1);
    ST = 7'd52; tick(3); check("heat_52", heater, 1'b0);
    ST = 7'd61; tick(3); check("cool_61", cooler, 1'b1);
    ST = 7'd59; tick(3); check("cool_59", cooler, 1'b1);
    ST = 7'd58; tick(3); check("cool_58", cooler, 1'b0);
    ST = 7'd55; tick(3);

    // Rear door over window.
    SRD = 1'b1;
    SW  = W_HI;
    tick(LAT + 1);
    check("dw_rdoor", rdoor, 1'b1);
    check("dw_display_rdoor", display, 3'd2);
    SRD = 1'b0;
    tick(DEBOUNCE + DOOR_HOLD + 3);
    check("dw_winbuzz", winbuzz, 1'b1);
    check("dw_win_open", win_open, W_HI);
    check("dw_display_win", display, 3'd3);
    SW = '0;
    tick(LAT + 2);
    check("dw_idle", display, 3'd0);

    // Reset in the middle of a door hold.
    SFD = 1'b1;
    tick(LAT + 1);
    SFD = 1'b0;
    tick(DEBOUNCE + 3);
    check("mid_hold_fdoor_on", fdoor, 1'b1);
    Rst = 1'b1;
    tick();
    check("mid_hold_rst_fdoor", fdoor, 1'b0);
    check("mid_hold_rst_timer", 32'(dut.hold_cnt), 32'd0);
    Rst = 1'b0;
    tick(5);

    // Randomized traffic, checked by the model every cycle.
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(9) == 0) SFD = ~SFD;
      if ($urandom_range(9) == 0) SRD = ~SRD;
      for (int b = 0; b < N_WIN; b++) if ($urandom_range(9) == 0) SW[b] = ~SW[b];
      if ($urandom_range(39) == 0) SFA = ~SFA;
      alarm_ack = ($urandom_range(3) == 0);
      if ($urandom_range(7) == 0) ST = TEMP_W'($urandom_range(66, 44));
      Rst = ($urandom_range(299) == 0);
      tick();
    end

    Rst = 1'b0;
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
